multu_hilo_sequencer: RTL and testbench
=======================================

// Module: multu_hilo_sequencer
// PURPOSE
//  Multi-cycle unsigned multiply engine and HI/LO register owner for the pipelined CPU's EX stage.
//  - Starts on the ALU control's MULTU decode.
//  - Runs an iterative shift-add multiply and commits the product to HI/LO.
//  - Serves MFHI/MFLO reads, and stalls the pipeline while a result is pending.
// PARAMETERS
//  WIDTH           32  operand width; HI and LO are WIDTH bits each
//  BITS_PER_CYCLE  1   multiplier bits retired per RUN cycle; legal values 1, 2, 4; must divide WIDTH
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      reset: synchronous, active-high
//  start         in   1      MULTU issue (SignaltoMULTU qualified by EX valid)
//  flush         in   1      squash in-flight multiply (branch/JR redirect)
//  op_a          in   WIDTH  multiplicand (rs)
//  op_b          in   WIDTH  multiplier (rt)
//  rd_hi         in   1      MFHI in EX (SignaltoHi)
//  rd_lo         in   1      MFLO in EX (SignaltoLo)
//  busy          out  1      1 while state==RUN
//  stall         out  1      freeze IF/ID/EX
//  done          out  1      1-cycle pulse: HI/LO just committed
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
//  hilo_rd_data  out  WIDTH  read data for MFHI/MFLO
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, stall=0, hi=0, lo=0; count=0, accumulator=0.
//    Reset during RUN aborts the multiply; no done pulse.
//  - Let N = WIDTH/BITS_PER_CYCLE.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE:
//    - start=1 & flush=0: latch mcand={WIDTH'b0,op_a} (2*WIDTH bits), mplier=op_b, acc=0, count=N; go to RUN.
//    - start=1 & flush=1: start is ignored; stay in IDLE.
//  - RUN, each cycle:
//    - acc += mcand * mplier[BITS_PER_CYCLE-1:0]
//    - mcand <<= BITS_PER_CYCLE; mplier >>= BITS_PER_CYCLE; count -= 1
//    - On the cycle with count==1: load {hi,lo} from the final acc value (including this cycle's addition); go to DONE.
//    - Arithmetic is unsigned, modulo 2^(2*WIDTH); no overflow is possible.
//    - op_a/op_b changes during RUN are ignored, because operands are latched at start.
//  - flush in RUN: go to IDLE next cycle; hi/lo keep their previous values; no done pulse.
//  - flush has priority over count==1.
//  - DONE: done=1 for exactly this cycle; hi/lo are valid.
//    - start=1 in DONE is accepted exactly as in IDLE (back-to-back MULTU); otherwise go to IDLE.
//  - Latency: start sampled in cycle 0; RUN occupies cycles 1..N; done=1 and new hi/lo in cycle N+1.
//  - stall = busy & (start | rd_hi | rd_lo), combinational.
//    - start while busy means the second MULTU is held in EX until DONE.
//  - hilo_rd_data, combinational:
//    - rd_hi=1 → hi (rd_hi wins if both are set)
//    - rd_lo=1 only → lo
//    - neither → 0
//  - start arriving in RUN without a stall is a protocol error; the block ignores it.
// CONFIGURATION
//  MULTU_EARLY_TERM_EN
//    - Defined: in RUN, when the post-shift mplier is zero, commit hi/lo and go to DONE on that cycle regardless of count.
//      - RUN length = max(1, ceil((msb_index(op_b)+1)/BITS_PER_CYCLE)).
//      - op_b==0 takes 1 RUN cycle.
//    - Undefined: RUN is always exactly N cycles.
// TESTING
//  1. Basic product (BITS_PER_CYCLE=1): rst, then start with op_a=3, op_b=5
//     → busy=1 in cycles 1..32; done=1 in cycle 33; hi=0, lo=15.
//  2. Maximum operands: op_a=op_b=32'hFFFFFFFF
//     → hi=32'hFFFFFFFE, lo=32'h00000001 at done.
//  3. MFLO interlock: rd_lo=1 held from cycle 5 of RUN
//     → stall=1 until RUN ends; in DONE stall=0 and hilo_rd_data=lo.
//  4. Flush: after test 2, start op_a=9, op_b=9, then flush in RUN cycle 10
//     → IDLE next cycle, no done, hi/lo unchanged (FFFFFFFE/00000001).
//  5. Back-to-back: start op_a=2, op_b=7 asserted in the DONE cycle of a prior multiply
//     → accepted; done 33 cycles later; lo=14.
//  6. Reset mid-RUN: rst in RUN cycle 12 → all outputs 0 next cycle.
//     Early termination, with MULTU_EARLY_TERM_EN defined: op_b=1
//     → done=1 in cycle 2, lo=op_a.

Source files
------------

// File: rtl/multu_hilo_sequencer.sv
// Iterative unsigned shift-add multiplier that owns the HI/LO pair and stalls EX while busy.
// Optional build macro MULTU_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are zero.
module multu_hilo_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_rd_data
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [PW-1:0]    mcand_r, mcand_s;
  logic [PW-1:0]    acc_r, acc_s;
  logic [PW-1:0]    step_sum_s;
  logic [WIDTH-1:0] mplier_r, mplier_s, mplier_shift_s;
  logic [WIDTH-1:0] hi_r, hi_s, lo_r, lo_s;
  logic [CW-1:0]    count_r, count_s;
  logic             last_s;

  // Multiplicand times one multiplier digit, built from shifted copies.
  function automatic logic [PW-1:0] partial_product(input logic [PW-1:0] mc,
                                                    input logic [BITS_PER_CYCLE-1:0] digit);
    logic [PW-1:0] sum;
    sum = {PW{1'b0}};
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (digit[k]) begin
        sum = sum + (mc << k);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // Next-state and datapath update for the multiply sequencer.
  always_comb begin
    state_s        = state_r;
    mcand_s        = mcand_r;
    mplier_s       = mplier_r;
    acc_s          = acc_r;
    count_s        = count_r;
    hi_s           = hi_r;
    lo_s           = lo_r;
    step_sum_s     = acc_r + partial_product(mcand_r, mplier_r[BITS_PER_CYCLE-1:0]);
    mplier_shift_s = mplier_r >> BITS_PER_CYCLE;
`ifdef MULTU_EARLY_TERM_EN
    last_s = (count_r == CW'(1)) || (mplier_shift_s == {WIDTH{1'b0}});
`else
    last_s = (count_r == CW'(1));
`endif
    case (state_r)
      IDLE, DONE: begin
        // DONE accepts a new MULTU exactly like IDLE, giving back-to-back issue.
        if (start && !flush) begin
          state_s  = RUN;
          mcand_s  = {{WIDTH{1'b0}}, op_a};
          mplier_s = op_b;
          acc_s    = {PW{1'b0}};
          count_s  = CW'(N);
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          acc_s    = step_sum_s;
          mcand_s  = mcand_r << BITS_PER_CYCLE;
          mplier_s = mplier_shift_s;
          count_s  = count_r - CW'(1);
          if (last_s) begin
            state_s = DONE;
            hi_s    = step_sum_s[PW-1:WIDTH];
            lo_s    = step_sum_s[WIDTH-1:0];
          end else begin
            state_s = RUN;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      count_r  <= count_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
    end
  end

  // MFHI/MFLO read mux; HI wins when both reads are asserted.
  always_comb begin
    if (rd_hi) begin
      hilo_rd_data = hi_r;
    end else if (rd_lo) begin
      hilo_rd_data = lo_r;
    end else begin
      hilo_rd_data = {WIDTH{1'b0}};
    end
  end

  assign busy  = (state_r == RUN);
  assign done  = (state_r == DONE);
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign stall = busy & (start | rd_hi | rd_lo);

endmodule

// File: tb/tb_multu_hilo_sequencer.sv
// Scoreboard bench for multu_hilo_sequencer: products queued at issue, compared at the done pulse.
module tb_multu_hilo_sequencer;
  localparam int W = 32;
  localparam int B = 1;
  localparam int N = W / B;
`ifdef MULTU_EARLY_TERM_EN
  localparam int FLUSH_CYC = 2;
`else
  localparam int FLUSH_CYC = 10;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, flush = 1'b0, rd_hi = 1'b0, rd_lo = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo, hilo_rd_data;

  int checks = 0;
  int passed = 0;
  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];

  multu_hilo_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(B)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op_a(op_a), .op_b(op_b),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo), .hilo_rd_data(hilo_rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int run_len(input logic [W-1:0] b);
`ifdef MULTU_EARLY_TERM_EN
    int m;
    m = 0;
    for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
    return (m == 0) ? 1 : (m + B - 1) / B;
`else
    return N;
`endif
  endfunction

  // Drive a MULTU in the current cycle and queue its expected product and RUN length.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back(p);
    lat_q.push_back(run_len(b));
  endtask

  // Let the queued multiply run (scrambling operands) and check it at done.
  task automatic wait_done(input string name);
    logic [2*W-1:0] e;
    int l, c, nb;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    step();
    start = 1'b0;
    c = 1;
    nb = 0;
    while (done !== 1'b1 && c < N + 5) begin
      if (busy === 1'b1) nb++;
      op_a = $urandom;
      op_b = $urandom;
      step();
      c++;
    end
    checks++;
    if (done === 1'b1 && c == l + 1) passed++;
    else $display("FAIL %s_latency: done=%b at cycle %0d, expected done=1 at cycle %0d", name, done, c, l + 1);
    checks++;
    if (nb == l) passed++;
    else $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, nb, l);
    checks++;
    if ({hi, lo} === e) passed++;
    else $display("FAIL %s_product: got %h_%h, expected %h_%h", name, hi, lo, e[2*W-1:W], e[W-1:0]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if ({busy, done, stall} === 3'b000) passed++;
    else $display("FAIL reset_flags: got busy/done/stall=%b, expected 000", {busy, done, stall});
    checks++;
    if (hi === 32'h0 && lo === 32'h0 && hilo_rd_data === 32'h0) passed++;
    else $display("FAIL reset_hilo: got hi=%h lo=%h rd=%h, expected all 0", hi, lo, hilo_rd_data);
  endtask

  task automatic test_basic();
    issue(32'd3, 32'd5);
    wait_done("basic");
    checks++;
    if (hi === 32'h0 && lo === 32'd15) passed++;
    else $display("FAIL basic_const: got hi=%h lo=%h, expected 0/f", hi, lo);
    step();
  endtask

  task automatic test_max();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max");
    checks++;
    if (hi === 32'hFFFF_FFFE && lo === 32'h0000_0001) passed++;
    else $display("FAIL max_const: got hi=%h lo=%h, expected fffffffe/00000001", hi, lo);
    step();
  endtask

  task automatic test_flush();
    int seen_done;
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    step();
    checks++;
    if (busy === 1'b0) passed++;
    else $display("FAIL start_with_flush: got busy=%b, expected 0", busy);
    flush = 1'b0;
    step();
    start = 1'b0;
    repeat (FLUSH_CYC - 1) step();
    checks++;
    if (busy === 1'b1) passed++;
    else $display("FAIL flush_pre_busy: got busy=%b, expected 1", busy);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy === 1'b0 && done === 1'b0) passed++;
    else $display("FAIL flush_idle: got busy=%b done=%b, expected 0/0", busy, done);
    checks++;
    if (hi === 32'hFFFF_FFFE && lo === 32'h0000_0001) passed++;
    else $display("FAIL flush_hilo: got hi=%h lo=%h, expected fffffffe/00000001", hi, lo);
    seen_done = 0;
    repeat (N + 2) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    checks++;
    if (seen_done == 0) passed++;
    else $display("FAIL flush_quiet: got activity=%0d, expected 0", seen_done);
  endtask

  task automatic test_mflo_interlock();
    logic [2*W-1:0] e;
    int c, bad;
    issue(32'h1234_5678, 32'h8000_0001);
    e = exp_q.pop_front();
    void'(lat_q.pop_front());
    step();
    start = 1'b0;
    repeat (4) step();
    rd_lo = 1'b1;
    #1;
    c = 5;
    bad = 0;
    while (busy === 1'b1 && c < N + 5) begin
      if (stall !== 1'b1) bad++;
      step();
      c++;
    end
    checks++;
    if (bad == 0 && c == N + 1) passed++;
    else $display("FAIL mflo_stall: got %0d unstalled RUN cycles ending at %0d, expected 0 ending at %0d", bad, c, N + 1);
    checks++;
    if (done === 1'b1 && stall === 1'b0) passed++;
    else $display("FAIL mflo_done_stall: got done=%b stall=%b, expected 1/0", done, stall);
    checks++;
    if (hilo_rd_data === e[W-1:0]) passed++;
    else $display("FAIL mflo_data: got %h, expected %h", hilo_rd_data, e[W-1:0]);
    rd_hi = 1'b1;
    #1;
    checks++;
    if (hilo_rd_data === e[2*W-1:W]) passed++;
    else $display("FAIL mfhi_priority: got %h, expected %h", hilo_rd_data, e[2*W-1:W]);
    rd_hi = 1'b0;
    rd_lo = 1'b0;
    #1;
    checks++;
    if (hilo_rd_data === 32'h0) passed++;
    else $display("FAIL rd_none: got %h, expected 0", hilo_rd_data);
    step();
  endtask

  task automatic test_back_to_back();
    issue(32'd4, 32'd6);
    wait_done("b2b_first");
    issue(32'd2, 32'd7);
    wait_done("b2b_second");
    checks++;
    if (lo === 32'd14) passed++;
    else $display("FAIL b2b_const: got lo=%h, expected e", lo);
    step();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    op_a  = 32'd11;
    op_b  = 32'd13;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    start = 1'b1;
    #1;
    checks++;
    if (stall === 1'b1 && busy === 1'b1) passed++;
    else $display("FAIL start_while_busy: got stall=%b busy=%b, expected 1/1", stall, busy);
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, stall} === 3'b000 && hi === 32'h0 && lo === 32'h0) passed++;
    else $display("FAIL midrun_reset: got busy/done/stall=%b hi=%h lo=%h, expected 000/0/0", {busy, done, stall}, hi, lo);
    seen = 0;
    repeat (N + 3) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) passed++;
    else $display("FAIL midrun_no_done: got done pulse, expected none");
  endtask

  task automatic test_sparse_operands();
    issue(32'hDEAD_BEEF, 32'd1);
    wait_done("mul_by_one");
    issue(32'hCAFE_F00D, 32'd0);
    wait_done("mul_by_zero");
    issue(32'h0001_0000, 32'h0000_0300);
    wait_done("mul_mid");
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_flush();
    test_mflo_interlock();
    test_back_to_back();
    test_reset_mid_run();
    test_sparse_operands();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
